// File: rtl/inst_mem_resp.sv
// Instruction-memory responder for the fetch stage: one word per request after WAIT_CYCLES wait states.
// Optional define INST_MISALIGN_CHK_EN: unaligned fetches return a NOP and pulse o_misalign.
`timescale 1ns/1ps
module inst_mem_resp #(
  parameter int N_ADDR      = 32,
  parameter int N_DATA      = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ce,
  input  logic [N_ADDR-1:0]     i_pc,
  output logic [N_DATA-1:0]     o_inst,
  output logic                  o_inst_vld,
  output logic                  o_stallreq,
  input  logic                  i_load_en,
  input  logic [DEPTH_LOG2-1:0] i_load_addr,
  input  logic [N_DATA-1:0]     i_load_data
`ifdef INST_MISALIGN_CHK_EN
  ,
  output logic                  o_misalign
`endif
);

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [3:0]              cnt;
  logic [3:0]              next_cnt;
  logic [N_ADDR-1:0]       pc_q;
  logic [N_ADDR-1:0]       next_pc;
  logic [N_DATA-1:0]       next_inst;
  logic                    next_vld;
  logic                    take;
  logic                    complete;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [N_DATA-1:0]       mem [0:(2**DEPTH_LOG2)-1];
`ifdef INST_MISALIGN_CHK_EN
  logic [1:0]              rd_lsb;
  logic                    next_mis;
`endif

  // Backdoor load port; not reset, and a same-edge fetch read sees the old word.
  always_ff @(posedge i_clk) begin
    if (i_load_en) begin
      mem[i_load_addr] <= i_load_data;
    end
  end

  assign o_stallreq = i_ce & ~(o_inst_vld & (i_pc == pc_q));

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    next_pc    = pc_q;
    next_inst  = o_inst;
    next_vld   = 1'b0;
    take       = 1'b0;
    complete   = 1'b0;
    rd_idx     = pc_q[DEPTH_LOG2+1:2];
`ifdef INST_MISALIGN_CHK_EN
    rd_lsb     = pc_q[1:0];
    next_mis   = 1'b0;
`endif
    case (state)
      IDLE: take = i_ce;
      BUSY: begin
        if (!i_ce) begin
          next_state = IDLE;
        end else if (i_pc != pc_q) begin
          take = 1'b1;
        end else if (cnt == 4'd0) begin
          complete = 1'b1;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase

    // A new request (from IDLE or a mid-wait address change) reads from the live PC.
    if (take) begin
      next_pc = i_pc;
      rd_idx  = i_pc[DEPTH_LOG2+1:2];
`ifdef INST_MISALIGN_CHK_EN
      rd_lsb  = i_pc[1:0];
`endif
      if (WAIT_CYCLES == 0) begin
        complete = 1'b1;
      end else begin
        next_cnt   = CNT_INIT;
        next_state = BUSY;
      end
    end else begin
      next_pc = pc_q;
    end

    if (complete) begin
      next_vld   = 1'b1;
      next_state = RESP;
`ifdef INST_MISALIGN_CHK_EN
      if (rd_lsb != 2'd0) begin
        next_inst = {N_DATA{1'b0}};
        next_mis  = 1'b1;
      end else begin
        next_inst = mem[rd_idx];
        next_mis  = 1'b0;
      end
`else
      next_inst = mem[rd_idx];
`endif
    end else begin
      next_vld = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      pc_q       <= {N_ADDR{1'b0}};
      o_inst     <= {N_DATA{1'b0}};
      o_inst_vld <= 1'b0;
`ifdef INST_MISALIGN_CHK_EN
      o_misalign <= 1'b0;
`endif
    end else begin
      state      <= next_state;
      cnt        <= next_cnt;
      pc_q       <= next_pc;
      o_inst     <= next_inst;
      o_inst_vld <= next_vld;
`ifdef INST_MISALIGN_CHK_EN
      o_misalign <= next_mis;
`endif
    end
  end

endmodule

// File: doc/inst_mem_resp.md
Name: inst_mem_resp

Overview:
- Responder end of the fetch interface: services the PC/chip-enable requests driven by the fetch stage.
- Returns one 32-bit instruction per request after a configurable number of wait states.
- Raises a stall request to pipeline control while a fetch is outstanding, so the PC holds through the stall-vector bit 0 path.
- Instruction storage is an internal word-addressed array, filled through a backdoor load port. This lets benches and boot logic write programs into it.

Parameters:
- N_ADDR, 32, width of the fetch address (i_pc).
- N_DATA, 32, instruction width.
- DEPTH_LOG2, 10, log2 of the number of instruction words stored.
- WAIT_CYCLES, 2, extra wait states per fetch; legal range 0..15.

Ports:
- i_clk  in  1  clock, all state on the rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_ce  in  1  fetch enable from the PC stage; 1 = request active.
- i_pc  in  N_ADDR  byte address of the requested instruction.
- o_inst  out  N_DATA  returned instruction word, registered.
- o_inst_vld  out  1  o_inst is valid for the current i_pc; one-cycle pulse per fetch.
- o_stallreq  out  1  fetch-stage stall request to pipeline control; combinational.
- i_load_en  in  1  backdoor write strobe.
- i_load_addr  in  DEPTH_LOG2  backdoor word index.
- i_load_data  in  N_DATA  backdoor write data.

Behaviour:
- Word index is i_pc[DEPTH_LOG2+1:2]. Bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the depth. Bits [1:0] are ignored unless the optional feature is enabled.
- Reset (async, i_rst=1):
  - Outputs: o_inst=0, o_inst_vld=0.
  - Internal state: state=IDLE, wait counter cnt=0, captured address pc_q=0.
  - Memory contents are not reset.
- o_stallreq = i_ce AND NOT(o_inst_vld AND i_pc==pc_q).
  - It is low whenever i_ce=0.
  - It is high during reset whenever i_ce=1.
- IDLE, on an edge with i_ce=1:
  - Capture pc_q<=i_pc.
  - If WAIT_CYCLES==0: load o_inst from memory, set o_inst_vld<=1, go to RESP.
  - Otherwise: set cnt<=WAIT_CYCLES-1, go to BUSY.
- BUSY:
  - On an edge with i_ce=0: abort, go to IDLE, no vld pulse.
  - On an edge with i_pc!=pc_q: restart exactly as from IDLE with the new i_pc.
  - Else if cnt==0: set o_inst<=mem[pc_q index], set o_inst_vld<=1, go to RESP.
  - Else: cnt<=cnt-1.
- RESP:
  - At the next edge, set o_inst_vld<=0 and go to IDLE unconditionally.
  - o_inst holds its value until the next fetch completes.
- Latency:
  - o_inst_vld rises after WAIT_CYCLES+1 rising edges, counting the capture edge.
  - Each sequential fetch occupies WAIT_CYCLES+2 cycles.
  - For back-to-back requests, the IDLE cycle after RESP accepts the next request.
- Backdoor load: mem[i_load_addr]<=i_load_data on any edge with i_load_en=1, in every state.
- Same-edge write and fetch read of the same word: the fetch returns the old data. A write on an earlier edge is visible.
- Reset asserted mid-fetch: immediate return to reset values. No vld pulse is produced for the aborted fetch.

Optional Feature:
- Macro: INST_MISALIGN_CHK_EN.
- When defined, a fetch whose captured i_pc[1:0]!=0 completes with normal latency, but returns o_inst=0 (NOP) instead of memory data. An extra output o_misalign is added; it is registered, reset 0, and pulses high in the same cycle as o_inst_vld.
- When not defined: no o_misalign port, and bits [1:0] are ignored entirely.

Test Plan:
- Reset then basic fetch (WAIT_CYCLES=2): load mem[0]=0x3401_1100; release reset; hold i_ce=1, i_pc=0 -> o_stallreq=1 for the capture edge and the 2 following edges; then o_inst=0x3401_1100, o_inst_vld=1, o_stallreq=0 for exactly one cycle.
- Sequential stream: load mem[0..3]=0xA0..0xA3; drive PC that advances by 4 only when o_stallreq=0 -> vld pulses every 4 cycles with 0xA0, 0xA1, 0xA2, 0xA3 in order.
- Abort: drop i_ce after 1 cycle of BUSY -> no vld pulse; state returns to IDLE; o_inst keeps its prior value; re-raising i_ce with i_pc=0x8 returns mem[2] with full latency.
- Address change mid-BUSY: i_pc switches 0x4 -> 0x10 during BUSY -> fetch restarts; vld occurs WAIT_CYCLES+1 edges after the switch with mem[4]; mem[1] is never returned.
- Wrap and load hazard: DEPTH_LOG2=10, fetch i_pc=0x1000 -> returns mem[0]; write mem[0]=0xDEAD_BEEF on the same edge as the RESP load -> old data returned, and the next fetch of 0x0 returns 0xDEAD_BEEF.
- Optional feature (INST_MISALIGN_CHK_EN defined): fetch i_pc=0x6 -> o_inst=0, o_misalign=1 with o_inst_vld; fetch i_pc=0x4 -> o_misalign=0, normal data.
